// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/sub datapath: default widths,
// alignment-window helpers and the sideband tag layout.
package fp_pkg;

  localparam int MANT_W_DEF = 8;
  localparam int EXP_W_DEF  = 8;
  localparam int GRS_W_DEF  = 3;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp;
    logic                 op;
  } fp_tag_t;

  function automatic int unsigned calc_w(input int unsigned mant_w, input int unsigned grs_w);
    return mant_w + grs_w;
  endfunction

  // Width needed to hold a shift amount in 0..w inclusive.
  function automatic int unsigned amt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  // The compare is done at the full input width, so large differences never alias.
  function automatic logic [31:0] sat_shamt(input logic [63:0] diff, input int unsigned w);
    return (diff >= 64'(w)) ? 32'(w) : diff[31:0];
  endfunction

endpackage

// File: rtl/fp_shift_sticky.sv
// Combinational right shift of a W-bit vector, returning the shifted value and
// the OR of every bit that fell off the bottom.
module fp_shift_sticky #(
  parameter int W    = 11,
  parameter int SH_W = 4
) (
  input  logic [W-1:0]    i_din,
  input  logic [SH_W-1:0] i_sh,
  output logic [W-1:0]    o_dout,
  output logic            o_sticky
);

  localparam logic [W-1:0] ONES = '1;

  logic [W-1:0] w_lost_mask;

  // A shift of W or more yields an all-ones mask, so everything counts as lost.
  assign w_lost_mask = ~(ONES << i_sh);
  assign o_dout      = i_din >> i_sh;
  assign o_sticky    = |(i_din & w_lost_mask);

endmodule

// File: rtl/fp_align_shift_pipe.sv
// Two-stage mantissa alignment shifter: coarse shift in stage 1, fine shift in
// stage 2, sticky accumulated across both, valid/ready on each side.
module fp_align_shift_pipe
  import fp_pkg::*;
#(
  parameter int MANT_W    = MANT_W_DEF,
  parameter int EXP_W     = EXP_W_DEF,
  parameter int GRS_W     = GRS_W_DEF,
  parameter int FINE_BITS = 2,
  parameter int TAG_W     = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [MANT_W-1:0]       mant_i,
  input  logic [EXP_W-1:0]        exp_diff_i,
  input  logic [TAG_W-1:0]        tag_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [MANT_W+GRS_W-1:0] mant_o,
  output logic                    sticky_o,
  output logic                    all_out_o,
  output logic [TAG_W-1:0]        tag_o
);

  localparam int W  = calc_w(MANT_W, GRS_W);
  localparam int AW = amt_w(W);
  localparam logic [AW-1:0] FINE_MASK = AW'((1 << FINE_BITS) - 1);

  logic [2:1] r_vld;
  logic       w_s1_ready, w_s2_ready;
  logic       w_s1_load,  w_s2_load;

  assign w_s2_ready  = !r_vld[2] || out_ready_i;
  assign w_s1_ready  = !r_vld[1] || w_s2_ready;
  assign in_ready_o  = w_s1_ready;
  assign w_s1_load   = in_valid_i && w_s1_ready;
  assign w_s2_load   = r_vld[1] && w_s2_ready;
  assign out_valid_o = r_vld[2];

  // Stage 1: saturate, coarse shift by the amount with its fine bits cleared.
  logic [W-1:0]  w_full, w_s1_shift;
  logic [AW-1:0] w_amt, w_amt_coarse;
  logic          w_s1_sticky, w_all_out;

  assign w_full       = {mant_i, {GRS_W{1'b0}}};
  assign w_amt        = AW'(sat_shamt(64'(exp_diff_i), W));
  assign w_amt_coarse = w_amt & ~FINE_MASK;
  assign w_all_out    = 64'(exp_diff_i) >= 64'(W);

  fp_shift_sticky #(.W(W), .SH_W(AW)) u_coarse (
    .i_din    (w_full),
    .i_sh     (w_amt_coarse),
    .o_dout   (w_s1_shift),
    .o_sticky (w_s1_sticky)
  );

  logic [W-1:0]         r_s1_mant;
  logic                 r_s1_sticky, r_s1_all_out;
  logic [FINE_BITS-1:0] r_s1_fine;
  logic [TAG_W-1:0]     r_s1_tag;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_mant    <= '0;
      r_s1_sticky  <= 1'b0;
      r_s1_all_out <= 1'b0;
      r_s1_fine    <= '0;
      r_s1_tag     <= '0;
    end else if (w_s1_load) begin
      r_s1_mant    <= w_s1_shift;
      r_s1_sticky  <= w_s1_sticky;
      r_s1_all_out <= w_all_out;
      r_s1_fine    <= w_amt[FINE_BITS-1:0];
      r_s1_tag     <= tag_i;
    end
  end

  // Stage 2: fine shift, folding its lost bits into the stage-1 sticky.
  logic [W-1:0] w_s2_shift;
  logic         w_s2_sticky;

  fp_shift_sticky #(.W(W), .SH_W(FINE_BITS)) u_fine (
    .i_din    (r_s1_mant),
    .i_sh     (r_s1_fine),
    .o_dout   (w_s2_shift),
    .o_sticky (w_s2_sticky)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mant_o    <= '0;
      sticky_o  <= 1'b0;
      all_out_o <= 1'b0;
      tag_o     <= '0;
    end else if (w_s2_load) begin
      mant_o    <= w_s2_shift;
      sticky_o  <= r_s1_sticky | w_s2_sticky;
      all_out_o <= r_s1_all_out;
      tag_o     <= r_s1_tag;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld <= '0;
    end else begin
      if (w_s1_ready) r_vld[1] <= in_valid_i;
      if (w_s2_ready) r_vld[2] <= r_vld[1];
    end
  end

endmodule

// File: tb/tb_fp_align_shift_pipe.sv
// Directed checks on the default configuration plus a randomized sweep of a
// 24-bit mantissa instance against the reference shift/sticky equations.
module tb_fp_align_shift_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Default instance (W = 11)
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]  a_mant, a_diff;
  logic [9:0]  a_tag, a_tag_o;
  logic [10:0] a_mant_o;
  logic        a_sticky, a_all_out;

  fp_align_shift_pipe u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .mant_i(a_mant), .exp_diff_i(a_diff), .tag_i(a_tag),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .mant_o(a_mant_o), .sticky_o(a_sticky), .all_out_o(a_all_out), .tag_o(a_tag_o)
  );

  // Wide instance (W = 27, three fine bits)
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [23:0] b_mant;
  logic [7:0]  b_diff;
  logic [9:0]  b_tag, b_tag_o;
  logic [26:0] b_mant_o;
  logic        b_sticky, b_all_out;

  fp_align_shift_pipe #(.MANT_W(24), .EXP_W(8), .GRS_W(3), .FINE_BITS(3), .TAG_W(10)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .mant_i(b_mant), .exp_diff_i(b_diff), .tag_i(b_tag),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .mant_o(b_mant_o), .sticky_o(b_sticky), .all_out_o(b_all_out), .tag_o(b_tag_o)
  );

  typedef struct {
    logic [63:0] mant;
    logic        sticky;
    logic        all_out;
    logic [9:0]  tag;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t ref_b(input logic [23:0] m, input logic [7:0] d, input logic [9:0] t);
    exp_t        e;
    logic [63:0] full, mask;
    int          amt;
    full      = {37'd0, m, 3'b000};
    amt       = (d >= 8'd27) ? 27 : int'(d);
    mask      = (64'd1 << amt) - 64'd1;
    e.mant    = full >> amt;
    e.sticky  = |(full & mask);
    e.all_out = (d >= 8'd27);
    e.tag     = t;
    return e;
  endfunction

  task automatic run_beat(input logic [7:0] m, input logic [7:0] d, input logic [9:0] t,
                          input logic [10:0] em, input logic es, input logic ea);
    @(negedge clk);
    a_in_valid = 1'b1; a_mant = m; a_diff = d; a_tag = t; a_out_ready = 1'b1;
    #1 chk("beat_in_ready", a_in_ready, 1);
    @(negedge clk);
    a_in_valid = 1'b0;
    #1 chk("beat_lat1_invalid", a_out_valid, 0);
    @(negedge clk);
    #1;
    chk("beat_lat2_valid", a_out_valid, 1);
    chk("beat_mant", a_mant_o, em);
    chk("beat_sticky", a_sticky, es);
    chk("beat_all_out", a_all_out, ea);
    chk("beat_tag", a_tag_o, t);
  endtask

  initial begin
    int idx, got;
    int sent, rcvd;
    rst = 1'b1;
    a_in_valid = 0; a_mant = 0; a_diff = 0; a_tag = 0; a_out_ready = 0;
    b_in_valid = 0; b_mant = 0; b_diff = 0; b_tag = 0; b_out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_mant", a_mant_o, 0);
    chk("rst_sticky", a_sticky, 0);
    chk("rst_all_out", a_all_out, 0);
    chk("rst_tag", a_tag_o, 0);
    chk("rst_in_ready", a_in_ready, 1);

    // Directed vectors, expected values worked out by hand
    run_beat(8'hFF, 8'd3,   10'h001, 11'h0FF, 1'b0, 1'b0);
    run_beat(8'hFF, 8'd4,   10'h002, 11'h07F, 1'b1, 1'b0);
    run_beat(8'h81, 8'd5,   10'h003, 11'h020, 1'b1, 1'b0);
    run_beat(8'h80, 8'd5,   10'h004, 11'h020, 1'b0, 1'b0);
    run_beat(8'hA5, 8'd0,   10'h005, 11'h528, 1'b0, 1'b0);
    run_beat(8'h80, 8'd10,  10'h006, 11'h001, 1'b0, 1'b0);
    run_beat(8'h01, 8'd11,  10'h007, 11'h000, 1'b1, 1'b1);
    run_beat(8'h01, 8'd200, 10'h008, 11'h000, 1'b1, 1'b1);
    run_beat(8'h00, 8'd200, 10'h009, 11'h000, 1'b0, 1'b1);
    run_beat(8'h00, 8'd6,   10'h00A, 11'h000, 1'b0, 1'b0);

    // Backpressure: five back-to-back beats, output stalled for four cycles
    @(negedge clk);
    a_out_ready = 1'b0;
    idx = 1; got = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      a_out_ready = (c >= 6);
      if (idx <= 5) begin
        a_in_valid = 1'b1; a_mant = 8'(8'h10 + idx); a_diff = 8'd0; a_tag = 10'(idx);
      end else a_in_valid = 1'b0;
      #1;
      if (c >= 2 && c <= 5) begin
        chk("bp_hold_valid", a_out_valid, 1);
        chk("bp_hold_tag", a_tag_o, 1);
        chk("bp_hold_mant", a_mant_o, 11'h088);
        chk("bp_in_ready_low", a_in_ready, 0);
      end
      if (a_out_valid && a_out_ready) begin
        got++;
        chk("bp_order_tag", a_tag_o, 64'(got));
        chk("bp_out_cycle", 64'(c), 64'(5 + got));
      end
      if (a_in_valid && a_in_ready) idx++;
    end
    a_in_valid = 1'b0;
    chk("bp_count", 64'(got), 5);

    // Reset with two beats in flight
    @(negedge clk);
    a_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1'b1; a_mant = 8'h55; a_diff = 8'd1; a_tag = 10'(100 + i);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", a_out_valid, 0);
    chk("mid_rst_in_ready", a_in_ready, 1);
    chk("mid_rst_tag", a_tag_o, 0);
    got = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1 if (a_out_valid) got++;
    end
    chk("mid_rst_no_stale", 64'(got), 0);

    // Wide-instance sweep against the reference equations
    sent = 0; rcvd = 0;
    for (int c = 0; c < 4000 && rcvd < 200; c++) begin
      @(negedge clk);
      b_out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 200 && !b_in_valid) begin
        b_in_valid = ($urandom_range(0, 4) != 0);
        b_mant = 24'($urandom);
        if ($urandom_range(0, 9) == 0) b_mant = 24'd0;
        b_diff = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 30));
        b_tag  = 10'(sent);
      end
      #1;
      if (b_out_valid && b_out_ready) begin
        if (sb.size() == 0) chk("sweep_unexpected_out", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sweep_tag", b_tag_o, e.tag);
          chk("sweep_mant", b_mant_o, e.mant);
          chk("sweep_sticky", b_sticky, e.sticky);
          chk("sweep_all_out", b_all_out, e.all_out);
        end
        rcvd++;
      end
      if (b_in_valid && b_in_ready) begin
        sb.push_back(ref_b(b_mant, b_diff, b_tag));
        sent++;
        @(posedge clk);
        #1 b_in_valid = 1'b0;
      end
    end
    b_in_valid = 1'b0;
    chk("sweep_count", 64'(rcvd), 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
